// File: rtl/rriscv_decode_stage.sv
// RV32/64 subset decode stage: 2-entry (output + skid) buffered decoder.
// Define RRISCV_DECODE_MUL_EN to decode MUL; otherwise MUL is illegal.
module rriscv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       out_op_o,
  output logic [4:0]       out_rd_o,
  output logic [4:0]       out_rs1_o,
  output logic [4:0]       out_rs2_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] dec_cnt_o
);

  typedef struct packed {
    logic [3:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } dec_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_J  = 7'b1101111;
  localparam logic [6:0] OPC_B  = 7'b1100011;

`ifdef RRISCV_DECODE_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        s;

  assign ins = in_instr_i;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];
  assign s   = ins[31];

  logic is_add, is_mul, is_xor, is_addi;
  logic is_lw, is_sw, is_jal, is_beq, is_bne;

  assign is_add  = opc == OPC_R && f3 == 3'b000 && f7 == 7'b0000000;
  assign is_mul  = opc == OPC_R && f3 == 3'b000 && f7 == 7'b0000001
                   && MUL_EN;
  assign is_xor  = opc == OPC_R && f3 == 3'b100 && f7 == 7'b0000000;
  assign is_addi = opc == OPC_I && f3 == 3'b000;
  assign is_lw   = opc == OPC_LD && f3 == 3'b010;
  assign is_sw   = opc == OPC_ST && f3 == 3'b010;
  assign is_jal  = opc == OPC_J;
  assign is_beq  = opc == OPC_B && f3 == 3'b000;
  assign is_bne  = opc == OPC_B && f3 == 3'b001;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign imm_i = {{(XLEN-12){s}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){s}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){s}}, s, ins[7], ins[30:25],
                  ins[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){s}}, s, ins[19:12], ins[20],
                  ins[30:21], 1'b0};

  dec_t dec;

  always_comb begin
    dec     = '0;
    dec.op  = 4'hF;
    dec.ill = 1'b1;
    dec.rd  = ins[11:7];
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    dec.pc  = in_pc_i;
    unique case (1'b1)
      is_add:  begin dec.op = 4'd0; dec.ill = 1'b0; end
      is_mul:  begin dec.op = 4'd1; dec.ill = 1'b0; end
      is_xor:  begin dec.op = 4'd2; dec.ill = 1'b0; end
      is_addi: begin
        dec.op = 4'd3; dec.ill = 1'b0; dec.imm = imm_i;
      end
      is_lw:   begin
        dec.op = 4'd4; dec.ill = 1'b0; dec.imm = imm_i;
      end
      is_sw:   begin
        dec.op = 4'd5; dec.ill = 1'b0; dec.imm = imm_s;
      end
      is_jal:  begin
        dec.op = 4'd6; dec.ill = 1'b0; dec.imm = imm_j;
      end
      is_beq:  begin
        dec.op = 4'd7; dec.ill = 1'b0; dec.imm = imm_b;
      end
      is_bne:  begin
        dec.op = 4'd8; dec.ill = 1'b0; dec.imm = imm_b;
      end
      default: ;
    endcase
  end

  dec_t            out_q, out_d, skid_q, skid_d;
  logic            out_vld_q, out_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept, xfer;

  assign in_ready_o = ~skid_vld_q;
  assign accept     = in_valid_i & ~skid_vld_q & ~flush_i;
  assign xfer       = out_vld_q & out_ready_i;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q + CNT_W'(xfer);
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (xfer) begin
      // skid full implies no accept this cycle
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      if (out_vld_q) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end else begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_q      <= '{op: 4'hF, default: '0};
      skid_q     <= '{op: 4'hF, default: '0};
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid_o   = out_vld_q;
  assign out_op_o      = out_q.op;
  assign out_rd_o      = out_q.rd;
  assign out_rs1_o     = out_q.rs1;
  assign out_rs2_o     = out_q.rs2;
  assign out_imm_o     = out_q.imm;
  assign out_pc_o      = out_q.pc;
  assign out_illegal_o = out_q.ill;
  assign dec_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rriscv_decode_stage.sv
// Directed testbench for rriscv_decode_stage.
// Expected values are hand-computed instruction encodings.
module tb_rriscv_decode_stage;

  logic        clk;
  logic        res_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [31:0] in_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_op_o;
  logic [4:0]  out_rd_o;
  logic [4:0]  out_rs1_o;
  logic [4:0]  out_rs2_o;
  logic [31:0] out_imm_o;
  logic [31:0] out_pc_o;
  logic        out_illegal_o;
  logic [31:0] dec_cnt_o;

  int n_chk;
  int n_fail;
  logic [31:0] exp_cnt;

  rriscv_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk           (clk),
    .res_n         (res_n),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .in_pc_i       (in_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_op_o      (out_op_o),
    .out_rd_o      (out_rd_o),
    .out_rs1_o     (out_rs1_o),
    .out_rs2_o     (out_rs2_o),
    .out_imm_o     (out_imm_o),
    .out_pc_o      (out_pc_o),
    .out_illegal_o (out_illegal_o),
    .dec_cnt_o     (dec_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    in_instr_i = '0;
    in_pc_i = '0;
    out_ready_i = 1'b0;
    #12;
    n_chk++;
    if ({out_valid_o, in_ready_o, out_illegal_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_flags: got v/r/ill=%b expected 010",
               {out_valid_o, in_ready_o, out_illegal_o});
    end
    n_chk++;
    if (out_op_o !== 4'hF || dec_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_op_cnt: got op=%h cnt=%h expected F/0",
               out_op_o, dec_cnt_o);
    end
    n_chk++;
    if ({out_rd_o, out_rs1_o, out_rs2_o, out_imm_o, out_pc_o} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_payload: got rd=%0d imm=%h pc=%h expected 0",
               out_rd_o, out_imm_o, out_pc_o);
    end
    @(negedge clk);
    res_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_decode();
    logic [31:0] ins [10];
    logic [3:0]  eop [10];
    logic [4:0]  erd [10];
    logic [4:0]  ers1 [10];
    logic [4:0]  ers2 [10];
    logic [31:0] eimm [10];
    logic        eill [10];
    ins  = '{32'h00500093, 32'hFE000EE3, 32'h022081B3, 32'h002081B3,
             32'h0020C1B3, 32'h01012283, 32'hFE20AC23, 32'h001000EF,
             32'h00209463, 32'hFFFFFFFF};
    eop  = '{4'd3, 4'd7, 4'd1, 4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15};
    erd  = '{5'd1, 5'd29, 5'd3, 5'd3, 5'd3, 5'd5, 5'd24, 5'd1, 5'd8, 5'd31};
    ers1 = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd1, 5'd0, 5'd1, 5'd31};
    ers2 = '{5'd5, 5'd0, 5'd2, 5'd2, 5'd2, 5'd16, 5'd2, 5'd1, 5'd2, 5'd31};
    eimm = '{32'd5, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd0, 32'd16,
             32'hFFFFFFF8, 32'h800, 32'd8, 32'd0};
    eill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifndef RRISCV_DECODE_MUL_EN
    eop[2]  = 4'd15;
    eill[2] = 1'b1;
`endif
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      in_instr_i = ins[i];
      in_pc_i = 32'h1000 + 32'(i * 4);
      step();
      in_valid_i = 1'b0;
      n_chk++;
      if (out_valid_o !== 1'b1 || out_op_o !== eop[i] ||
          out_illegal_o !== eill[i]) begin
        n_fail++;
        $display("FAIL dec%0d_op: got v=%b op=%0d ill=%b expected 1/%0d/%b",
                 i, out_valid_o, out_op_o, out_illegal_o, eop[i], eill[i]);
      end
      n_chk++;
      if (out_rd_o !== erd[i] || out_rs1_o !== ers1[i] ||
          out_rs2_o !== ers2[i]) begin
        n_fail++;
        $display("FAIL dec%0d_regs: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 i, out_rd_o, out_rs1_o, out_rs2_o,
                 erd[i], ers1[i], ers2[i]);
      end
      n_chk++;
      if (out_imm_o !== eimm[i] || out_pc_o !== 32'h1000 + 32'(i * 4))
      begin
        n_fail++;
        $display("FAIL dec%0d_imm: got imm=%h pc=%h expected imm=%h",
                 i, out_imm_o, out_pc_o, eimm[i]);
      end
      step();
      exp_cnt++;
      n_chk++;
      if (out_valid_o !== 1'b0 || dec_cnt_o !== exp_cnt) begin
        n_fail++;
        $display("FAIL dec%0d_cnt: got v=%b cnt=%0d expected 0/%0d",
                 i, out_valid_o, dec_cnt_o, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00500093;
    in_pc_i = 32'hA0;
    step();
    n_chk++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 ||
        out_pc_o !== 32'hA0) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b rdy=%b pc=%h expected 1/1/a0",
               out_valid_o, in_ready_o, out_pc_o);
    end
    in_instr_i = 32'h002081B3;
    in_pc_i = 32'hA4;
    step();
    n_chk++;
    if (in_ready_o !== 1'b0 || out_pc_o !== 32'hA0 || out_op_o !== 4'd3)
    begin
      n_fail++;
      $display("FAIL bp_second: got rdy=%b pc=%h op=%0d expected 0/a0/3",
               in_ready_o, out_pc_o, out_op_o);
    end
    in_instr_i = 32'h0020C1B3;
    in_pc_i = 32'hA8;
    step();
    n_chk++;
    if (in_ready_o !== 1'b0 || out_pc_o !== 32'hA0 ||
        out_imm_o !== 32'd5 || dec_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b pc=%h imm=%h cnt=%0d",
               in_ready_o, out_pc_o, out_imm_o, dec_cnt_o);
    end
    out_ready_i = 1'b1;
    step();
    exp_cnt++;
    n_chk++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'hA4 ||
        out_op_o !== 4'd0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rel1: got v=%b pc=%h op=%0d rdy=%b expected 1/a4/0/1",
               out_valid_o, out_pc_o, out_op_o, in_ready_o);
    end
    step();
    exp_cnt++;
    in_valid_i = 1'b0;
    n_chk++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'hA8 || out_op_o !== 4'd2)
    begin
      n_fail++;
      $display("FAIL bp_rel2: got v=%b pc=%h op=%0d expected 1/a8/2",
               out_valid_o, out_pc_o, out_op_o);
    end
    step();
    exp_cnt++;
    n_chk++;
    if (out_valid_o !== 1'b0 || dec_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b cnt=%0d expected 0/%0d",
               out_valid_o, dec_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00500093;
    in_pc_i = 32'hB0;
    step();
    in_pc_i = 32'hB4;
    step();
    in_pc_i = 32'hB8;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    n_chk++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        dec_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b rdy=%b cnt=%0d expected 0/1/%0d",
               out_valid_o, in_ready_o, dec_cnt_o, exp_cnt);
    end
    out_ready_i = 1'b1;
    step();
    n_chk++;
    if (out_valid_o !== 1'b0 || dec_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_stale: got v=%b cnt=%0d expected 0/%0d",
               out_valid_o, dec_cnt_o, exp_cnt);
    end
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_pc_i = 32'hBC;
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    exp_cnt++;
    n_chk++;
    if (out_valid_o !== 1'b0 || dec_cnt_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_xfer: got v=%b cnt=%0d expected 0/%0d",
               out_valid_o, dec_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    #1;
    n_chk++;
    if (dec_cnt_o !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h expected ffffffff", dec_cnt_o);
    end
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'hFFFFFFFF;
    in_pc_i = 32'hC0;
    step();
    in_valid_i = 1'b0;
    step();
    exp_cnt = 32'd0;
    n_chk++;
    if (dec_cnt_o !== exp_cnt || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got cnt=%h v=%b expected 0/0",
               dec_cnt_o, out_valid_o);
    end
  endtask

  task automatic test_midreset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h01012283;
    in_pc_i = 32'hD0;
    step();
    step();
    out_ready_i = 1'b0;
    step();
    step();
    #2;
    res_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        dec_cnt_o !== 32'd0 || out_op_o !== 4'hF) begin
      n_fail++;
      $display("FAIL midrst_flags: got v=%b rdy=%b cnt=%0d op=%h",
               out_valid_o, in_ready_o, dec_cnt_o, out_op_o);
    end
    n_chk++;
    if (out_illegal_o !== 1'b0 || out_imm_o !== '0 || out_pc_o !== '0 ||
        out_rd_o !== '0 || out_rs1_o !== '0 || out_rs2_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_payload: got ill=%b imm=%h pc=%h rd=%0d",
               out_illegal_o, out_imm_o, out_pc_o, out_rd_o);
    end
    @(negedge clk);
    res_n = 1'b1;
    in_instr_i = 32'h00209463;
    in_pc_i = 32'hE0;
    step();
    in_valid_i = 1'b0;
    n_chk++;
    if (out_valid_o !== 1'b1 || out_op_o !== 4'd8 ||
        out_pc_o !== 32'hE0 || out_imm_o !== 32'd8) begin
      n_fail++;
      $display("FAIL midrst_resume: got v=%b op=%0d pc=%h imm=%h",
               out_valid_o, out_op_o, out_pc_o, out_imm_o);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_cnt = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
